// File: rtl/replica_exchange_ctrl.sv
// Replica-exchange (parallel tempering) sequencer.
// Alternates OPT_CYCLES opt sweeps with one exchange phase. The exchange phase
// walks even or odd neighbour pairs, collects Metropolis decisions and then
// hands a per-replica exchange command vector downstream over valid/ready.
// Command encoding per replica: NOP=0, SELF=1, PREV=2 (take partner below),
// FOLW=3 (take partner above).
module replica_exchange_ctrl #(
    parameter int REPLICA_NUM = 32,
    parameter int OPT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                total_rounds,
    output logic                       opt_run,
    input  logic                       opt_done,
    output logic                       pair_req,
    output logic [6:0]                 pair_idx,
    input  logic                       pair_ack,
    input  logic                       pair_accept,
    output logic [2*REPLICA_NUM-1:0]   exchange_cmd,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                round_cnt
);

    localparam logic [1:0]  CMD_NOP    = 2'd0;
    localparam logic [1:0]  CMD_SELF   = 2'd1;
    localparam logic [1:0]  CMD_PREV   = 2'd2;
    localparam logic [1:0]  CMD_FOLW   = 2'd3;
    localparam logic [15:0] SWEEP_LAST = 16'(OPT_CYCLES - 1);
    localparam logic [8:0]  REP_NUM9   = 9'(REPLICA_NUM);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPT_ISSUE = 3'd1,
        S_OPT_WAIT  = 3'd2,
        S_PAIR_REQ  = 3'd3,
        S_PAIR_WAIT = 3'd4,
        S_APPLY     = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    // True when pair (p, p+1) lies inside the replica range.
    function automatic logic pair_fits(input logic [7:0] p);
        return (({1'b0, p} + 9'd1) < REP_NUM9);
    endfunction

    // Command vector with every replica entry set to the same code.
    function automatic logic [2*REPLICA_NUM-1:0] fill_cmd(input logic [1:0] c);
        logic [2*REPLICA_NUM-1:0] v;
        v = '0;
        for (int i = 0; i < REPLICA_NUM; i++) begin
            v[2*i +: 2] = c;
        end
        return v;
    endfunction

    state_t                     state_r, state_s;
    logic [15:0]                total_r, total_s;
    logic [15:0]                round_r, round_s;
    logic [15:0]                sweep_r, sweep_s;
    logic                       parity_r, parity_s;
    logic [7:0]                 p_r, p_s;
    logic [2*REPLICA_NUM-1:0]   cmd_r, cmd_s;
    logic                       opt_run_r, opt_run_s;
    logic                       pair_req_r, pair_req_s;
    logic                       cmd_valid_r, cmd_valid_s;
    logic                       busy_r, busy_s;
    logic                       done_r, done_s;

    logic                       sweep_last_s;
    logic [16:0]                round_inc_s;
    logic                       round_hit_s;

    assign sweep_last_s = (sweep_r == SWEEP_LAST);
    assign round_inc_s  = {1'b0, round_r} + 17'd1;
    assign round_hit_s  = (round_inc_s == {1'b0, total_r});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = (total_rounds == 16'd0) ? S_FINISH : S_OPT_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_OPT_ISSUE: begin
                state_s = S_OPT_WAIT;
            end
            S_OPT_WAIT: begin
                if (opt_done && sweep_last_s) begin
                    // Odd phase with only two replicas has no pair at all.
                    state_s = pair_fits({7'd0, parity_r}) ? S_PAIR_REQ : S_APPLY;
                end else if (opt_done) begin
                    state_s = S_OPT_ISSUE;
                end else begin
                    state_s = S_OPT_WAIT;
                end
            end
            S_PAIR_REQ, S_PAIR_WAIT: begin
                if (pair_ack) begin
                    state_s = pair_fits(p_r + 8'd2) ? S_PAIR_REQ : S_APPLY;
                end else begin
                    state_s = S_PAIR_WAIT;
                end
            end
            S_APPLY: begin
                if (cmd_ready) begin
                    state_s = round_hit_s ? S_FINISH : S_OPT_ISSUE;
                end else begin
                    state_s = S_APPLY;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; outputs decode the upcoming state so they register in step with it.
    always_comb begin
        total_s     = total_r;
        round_s     = round_r;
        sweep_s     = sweep_r;
        parity_s    = parity_r;
        p_s         = p_r;
        cmd_s       = cmd_r;
        opt_run_s   = (state_s == S_OPT_ISSUE);
        pair_req_s  = (state_s == S_PAIR_REQ) || (state_s == S_PAIR_WAIT);
        cmd_valid_s = (state_s == S_APPLY);
        busy_s      = (state_s != S_IDLE);
        done_s      = (state_s == S_FINISH);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    total_s  = total_rounds;
                    round_s  = 16'd0;
                    parity_s = 1'b0;
                    sweep_s  = 16'd0;
                    p_s      = 8'd0;
                end else begin
                    cmd_s = fill_cmd(CMD_NOP);
                end
            end
            S_OPT_WAIT: begin
                if (opt_done && sweep_last_s) begin
                    sweep_s = 16'd0;
                    p_s     = {7'd0, parity_r};
                    cmd_s   = fill_cmd(CMD_SELF);
                end else if (opt_done) begin
                    sweep_s = sweep_r + 16'd1;
                end else begin
                    sweep_s = sweep_r;
                end
            end
            S_PAIR_REQ, S_PAIR_WAIT: begin
                if (pair_ack) begin
                    p_s = p_r + 8'd2;
                    for (int i = 0; i < REPLICA_NUM; i++) begin
                        if (pair_accept && (8'(i) == p_r)) begin
                            cmd_s[2*i +: 2] = CMD_FOLW;
                        end else if (pair_accept && (8'(i) == (p_r + 8'd1))) begin
                            cmd_s[2*i +: 2] = CMD_PREV;
                        end else begin
                            cmd_s[2*i +: 2] = cmd_r[2*i +: 2];
                        end
                    end
                end else begin
                    p_s = p_r;
                end
            end
            S_APPLY: begin
                if (cmd_ready) begin
                    parity_s = ~parity_r;
                    round_s  = round_inc_s[15:0];
                    p_s      = 8'd0;
                    cmd_s    = fill_cmd(CMD_NOP);
                end else begin
                    cmd_s = cmd_r;
                end
            end
            default: begin
                cmd_s = fill_cmd(CMD_NOP);
            end
        endcase
    end

    // Registered outputs and run bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_r     <= 16'd0;
            round_r     <= 16'd0;
            sweep_r     <= 16'd0;
            parity_r    <= 1'b0;
            p_r         <= 8'd0;
            cmd_r       <= '0;
            opt_run_r   <= 1'b0;
            pair_req_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            total_r     <= total_s;
            round_r     <= round_s;
            sweep_r     <= sweep_s;
            parity_r    <= parity_s;
            p_r         <= p_s;
            cmd_r       <= cmd_s;
            opt_run_r   <= opt_run_s;
            pair_req_r  <= pair_req_s;
            cmd_valid_r <= cmd_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign opt_run      = opt_run_r;
    assign pair_req     = pair_req_r;
    assign pair_idx     = p_r[6:0];
    assign exchange_cmd = cmd_r;
    assign cmd_valid    = cmd_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign round_cnt    = round_r;

endmodule

// File: tb/tb_replica_exchange_ctrl.sv
// Directed bench for replica_exchange_ctrl: a 4-replica instance (2 sweeps per
// phase) and a 5-replica instance (1 sweep per phase) driven step by step.
module tb_replica_exchange_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    // Instance A: REPLICA_NUM=4, OPT_CYCLES=2
    logic        a_start, a_opt_run, a_opt_done, a_pair_req, a_pair_ack, a_pair_accept;
    logic        a_cmd_valid, a_cmd_ready, a_busy, a_done;
    logic [15:0] a_total, a_round;
    logic [6:0]  a_idx;
    logic [7:0]  a_cmd;

    // Instance B: REPLICA_NUM=5, OPT_CYCLES=1
    logic        b_start, b_opt_run, b_opt_done, b_pair_req, b_pair_ack, b_pair_accept;
    logic        b_cmd_valid, b_cmd_ready, b_busy, b_done;
    logic [15:0] b_total, b_round;
    logic [6:0]  b_idx;
    logic [9:0]  b_cmd;

    int n_cmp = 0;
    int n_err = 0;
    int opt_cnt = 0;
    int done_cnt = 0;
    int obase, dbase;

    replica_exchange_ctrl #(.REPLICA_NUM(4), .OPT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .total_rounds(a_total),
        .opt_run(a_opt_run), .opt_done(a_opt_done), .pair_req(a_pair_req),
        .pair_idx(a_idx), .pair_ack(a_pair_ack), .pair_accept(a_pair_accept),
        .exchange_cmd(a_cmd), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .busy(a_busy), .done(a_done), .round_cnt(a_round)
    );

    replica_exchange_ctrl #(.REPLICA_NUM(5), .OPT_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .total_rounds(b_total),
        .opt_run(b_opt_run), .opt_done(b_opt_done), .pair_req(b_pair_req),
        .pair_idx(b_idx), .pair_ack(b_pair_ack), .pair_accept(b_pair_accept),
        .exchange_cmd(b_cmd), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .busy(b_busy), .done(b_done), .round_cnt(b_round)
    );

    always #5 clk = ~clk;

    // Count opt_run and done high cycles of instance A, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_opt_run) opt_cnt++;
        if (a_done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Two issue/wait sweeps on instance A; ends with the phase in PAIR_REQ.
    task automatic a_opt_phase;
        repeat (2) begin
            chk("a_opt_run_hi", 32'(a_opt_run), 32'd1);
            tick;
            chk("a_opt_run_lo", 32'(a_opt_run), 32'd0);
            a_opt_done = 1'b1;
            tick;
            a_opt_done = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_total = 16'd0; a_opt_done = 1'b0; a_pair_ack = 1'b0;
        a_pair_accept = 1'b0; a_cmd_ready = 1'b0;
        b_start = 1'b0; b_total = 16'd0; b_opt_done = 1'b0; b_pair_ack = 1'b0;
        b_pair_accept = 1'b0; b_cmd_ready = 1'b0;
        #3;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_opt_run", 32'(a_opt_run), 32'd0);
        chk("rst_pair_req", 32'(a_pair_req), 32'd0);
        chk("rst_cmd_valid", 32'(a_cmd_valid), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_idx", 32'(a_idx), 32'd0);
        chk("rst_cmd", 32'(a_cmd), 32'd0);
        chk("rst_round", 32'(a_round), 32'd0);
        tick; tick;
        rst_n = 1'b1;
        tick;

        // One round, all accepted
        obase = opt_cnt; dbase = done_cnt;
        a_start = 1'b1; a_total = 16'd1;
        tick;
        a_start = 1'b0;
        chk("r1_busy", 32'(a_busy), 32'd1);
        chk("r1_cmd_nop", 32'(a_cmd), 32'd0);
        a_opt_phase;
        chk("r1_pair_req", 32'(a_pair_req), 32'd1);
        chk("r1_idx0", 32'(a_idx), 32'd0);
        chk("r1_preset", 32'(a_cmd), 32'h55);
        a_pair_ack = 1'b1; a_pair_accept = 1'b1;
        tick;
        chk("r1_idx2", 32'(a_idx), 32'd2);
        chk("r1_cmd_mid", 32'(a_cmd), 32'h5B);
        tick;
        a_pair_ack = 1'b0; a_pair_accept = 1'b0;
        chk("r1_req_off", 32'(a_pair_req), 32'd0);
        chk("r1_valid", 32'(a_cmd_valid), 32'd1);
        chk("r1_cmd", 32'(a_cmd), 32'hBB);
        a_cmd_ready = 1'b1;
        tick;
        a_cmd_ready = 1'b0;
        chk("r1_done", 32'(a_done), 32'd1);
        chk("r1_round", 32'(a_round), 32'd1);
        chk("r1_cmd_nop_fin", 32'(a_cmd), 32'd0);
        tick;
        chk("r1_idle", 32'(a_busy), 32'd0);
        chk("r1_opt_pulses", 32'(opt_cnt - obase), 32'd2);
        chk("r1_done_pulses", 32'(done_cnt - dbase), 32'd1);

        // Two rounds: reject then accept (odd parity), stalled APPLY
        a_start = 1'b1; a_total = 16'd2;
        tick;
        a_start = 1'b0;
        a_opt_phase;
        chk("r2_idx0", 32'(a_idx), 32'd0);
        tick;
        chk("r2_wait_req", 32'(a_pair_req), 32'd1);
        chk("r2_wait_idx", 32'(a_idx), 32'd0);
        tick;
        chk("r2_wait_idx2", 32'(a_idx), 32'd0);
        a_pair_ack = 1'b1; a_pair_accept = 1'b0;
        tick;
        chk("r2_idx2", 32'(a_idx), 32'd2);
        chk("r2_cmd_self", 32'(a_cmd), 32'h55);
        tick;
        a_pair_ack = 1'b0;
        chk("r2_valid", 32'(a_cmd_valid), 32'd1);
        chk("r2_cmd_rej", 32'(a_cmd), 32'h55);
        a_cmd_ready = 1'b1;
        tick;
        a_cmd_ready = 1'b0;
        chk("r2_round1", 32'(a_round), 32'd1);
        chk("r2_reissue", 32'(a_opt_run), 32'd1);
        chk("r2_cmd_nop", 32'(a_cmd), 32'd0);
        a_opt_phase;
        chk("r2_idx1", 32'(a_idx), 32'd1);
        chk("r2_preset", 32'(a_cmd), 32'h55);
        a_pair_ack = 1'b1; a_pair_accept = 1'b1;
        tick;
        a_pair_ack = 1'b0; a_pair_accept = 1'b0;
        chk("r2_apply", 32'(a_cmd_valid), 32'd1);
        chk("r2_cmd_odd", 32'(a_cmd), 32'h6D);
        a_opt_done = 1'b1; a_pair_ack = 1'b1; a_pair_accept = 1'b1;
        a_start = 1'b1; a_total = 16'd5;
        repeat (5) begin
            tick;
            chk("stall_valid", 32'(a_cmd_valid), 32'd1);
            chk("stall_cmd", 32'(a_cmd), 32'h6D);
            chk("stall_round", 32'(a_round), 32'd1);
            chk("stall_opt", 32'(a_opt_run), 32'd0);
        end
        a_opt_done = 1'b0; a_pair_ack = 1'b0; a_pair_accept = 1'b0;
        a_start = 1'b0;
        a_cmd_ready = 1'b1;
        tick;
        a_cmd_ready = 1'b0;
        chk("r2_done", 32'(a_done), 32'd1);
        chk("r2_round2", 32'(a_round), 32'd2);
        tick;
        chk("r2_idle", 32'(a_busy), 32'd0);

        // Reset in PAIR_WAIT during round 2
        dbase = done_cnt;
        a_start = 1'b1; a_total = 16'd3;
        tick;
        a_start = 1'b0;
        a_opt_phase;
        a_pair_ack = 1'b1; a_pair_accept = 1'b1;
        repeat (2) tick;
        a_pair_ack = 1'b0; a_pair_accept = 1'b0;
        a_cmd_ready = 1'b1;
        tick;
        a_cmd_ready = 1'b0;
        chk("rr_round1", 32'(a_round), 32'd1);
        a_opt_phase;
        tick;
        chk("rr_in_wait", 32'(a_pair_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_pair_req", 32'(a_pair_req), 32'd0);
        chk("rr_busy", 32'(a_busy), 32'd0);
        chk("rr_cmd", 32'(a_cmd), 32'd0);
        chk("rr_idx", 32'(a_idx), 32'd0);
        chk("rr_round", 32'(a_round), 32'd0);
        chk("rr_valid", 32'(a_cmd_valid), 32'd0);
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("rr_no_done", 32'(done_cnt - dbase), 32'd0);
        chk("rr_idle", 32'(a_busy), 32'd0);
        a_start = 1'b1; a_total = 16'd1;
        tick;
        a_start = 1'b0;
        chk("rr_new_round", 32'(a_round), 32'd0);
        a_opt_phase;
        chk("rr_new_idx", 32'(a_idx), 32'd0);
        a_pair_ack = 1'b1; a_pair_accept = 1'b1;
        repeat (2) tick;
        a_pair_ack = 1'b0; a_pair_accept = 1'b0;
        chk("rr_new_cmd", 32'(a_cmd), 32'hBB);
        a_cmd_ready = 1'b1;
        tick;
        a_cmd_ready = 1'b0;
        chk("rr_new_done", 32'(a_done), 32'd1);
        chk("rr_new_round1", 32'(a_round), 32'd1);
        tick;

        // Zero rounds
        obase = opt_cnt; dbase = done_cnt;
        a_start = 1'b1; a_total = 16'd0;
        tick;
        a_start = 1'b0;
        chk("z_busy", 32'(a_busy), 32'd1);
        chk("z_done", 32'(a_done), 32'd1);
        chk("z_opt_run", 32'(a_opt_run), 32'd0);
        chk("z_pair_req", 32'(a_pair_req), 32'd0);
        tick;
        chk("z_busy_off", 32'(a_busy), 32'd0);
        chk("z_done_off", 32'(a_done), 32'd0);
        chk("z_done_pulses", 32'(done_cnt - dbase), 32'd1);
        chk("z_no_opt", 32'(opt_cnt - obase), 32'd0);

        // Five replicas, two rounds, all accepted
        b_start = 1'b1; b_total = 16'd2;
        tick;
        b_start = 1'b0;
        chk("b_opt_run", 32'(b_opt_run), 32'd1);
        tick;
        b_opt_done = 1'b1;
        tick;
        b_opt_done = 1'b0;
        chk("b_even_idx0", 32'(b_idx), 32'd0);
        chk("b_preset", 32'(b_cmd), 32'h155);
        b_pair_ack = 1'b1; b_pair_accept = 1'b1;
        tick;
        chk("b_even_idx2", 32'(b_idx), 32'd2);
        tick;
        b_pair_ack = 1'b0; b_pair_accept = 1'b0;
        chk("b_even_valid", 32'(b_cmd_valid), 32'd1);
        chk("b_even_cmd", 32'(b_cmd), 32'h1BB);
        b_cmd_ready = 1'b1;
        tick;
        b_cmd_ready = 1'b0;
        chk("b_round1", 32'(b_round), 32'd1);
        tick;
        b_opt_done = 1'b1;
        tick;
        b_opt_done = 1'b0;
        chk("b_odd_idx1", 32'(b_idx), 32'd1);
        chk("b_odd_preset", 32'(b_cmd), 32'h155);
        b_pair_ack = 1'b1; b_pair_accept = 1'b1;
        tick;
        chk("b_odd_idx3", 32'(b_idx), 32'd3);
        tick;
        b_pair_ack = 1'b0; b_pair_accept = 1'b0;
        chk("b_odd_valid", 32'(b_cmd_valid), 32'd1);
        chk("b_odd_cmd", 32'(b_cmd), 32'h2ED);
        b_cmd_ready = 1'b1;
        tick;
        b_cmd_ready = 1'b0;
        chk("b_done", 32'(b_done), 32'd1);
        chk("b_round2", 32'(b_round), 32'd2);
        tick;
        chk("b_idle", 32'(b_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/replica_exchange_ctrl.md
REPLICA_EXCHANGE_CTRL -- requirements
Module: replica_exchange_ctrl

Interface
REQ-001 SHALL have parameter REPLICA_NUM, default 32, the number of replicas (temperatures), legal range 2..128.
REQ-002 SHALL have parameter OPT_CYCLES, default 16, the number of opt sweeps between exchange phases, legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a run; sampled only in IDLE.
REQ-006 SHALL have port total_rounds, input, 16 bits: number of opt+exchange rounds; captured on the start cycle.
REQ-007 SHALL have port opt_run, output, 1 bit: one-cycle pulse that launches one opt sweep on all replicas.
REQ-008 SHALL have port opt_done, input, 1 bit: sweep finished; valid only while waiting.
REQ-009 SHALL have port pair_req, output, 1 bit: request a Metropolis exchange decision for the pair given by pair_idx.
REQ-010 SHALL have port pair_idx, output, 7 bits: lower replica index p of pair (p, p+1).
REQ-011 SHALL have port pair_ack, input, 1 bit: decision valid.
REQ-012 SHALL have port pair_accept, input, 1 bit: 1 = swap accepted; qualified by pair_ack.
REQ-013 SHALL have port exchange_cmd, output, REPLICA_NUM x 2 bits: one exchange_command_t per replica.
REQ-014 SHALL have port cmd_valid, output, 1 bit, and port cmd_ready, input, 1 bit: valid/ready handshake for exchange_cmd.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-017 SHALL have port round_cnt, output, 16 bits: number of completed rounds.

Function
REQ-018 SHALL implement states IDLE, OPT_ISSUE, OPT_WAIT, PAIR_REQ, PAIR_WAIT, APPLY, FINISH.
REQ-019 IDLE: on start=1 SHALL capture total_rounds, clear round_cnt, set parity=0, and go to FINISH if total_rounds==0, else to OPT_ISSUE.
REQ-020 OPT_ISSUE SHALL assert opt_run for exactly one cycle, then go to OPT_WAIT.
REQ-021 OPT_WAIT, on opt_done, SHALL increment a sweep counter; below OPT_CYCLES it returns to OPT_ISSUE; at OPT_CYCLES it clears the counter and goes to PAIR_REQ with p=parity.
REQ-022 On entry to PAIR_REQ, every exchange_cmd entry SHALL be preset to SELF.
REQ-023 PAIR_REQ/PAIR_WAIT: pair_req and pair_idx=p SHALL be held stable from PAIR_REQ until the cycle pair_ack=1.
REQ-024 On pair_ack with pair_accept=1, entry p SHALL be set to FOLW and entry p+1 to PREV; on pair_accept=0 both entries stay SELF.
REQ-025 After each ack, p SHALL advance by 2; if p+1 > REPLICA_NUM-1 the controller goes to APPLY, else back to PAIR_REQ.
REQ-026 Replicas left without a pair SHALL stay SELF: replica 0 when parity=1, and the top replica when the pair count does not reach it.
REQ-027 In APPLY, cmd_valid=1 and exchange_cmd SHALL be held stable until cmd_ready=1; a transfer completes in the same cycle if cmd_ready is already high.
REQ-028 On transfer, the controller SHALL toggle parity and increment round_cnt; if the new round_cnt equals the captured total_rounds it goes to FINISH, else to OPT_ISSUE.
REQ-029 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-030 The following inputs SHALL be ignored: opt_done outside OPT_WAIT, pair_ack outside PAIR_REQ/PAIR_WAIT, and start while busy.
REQ-031 pair_ack SHALL be accepted in the same cycle pair_req first rises (zero-wait ack).
REQ-032 round_cnt SHALL be 16-bit unsigned; total_rounds=65535 is legal, and the counter never wraps within a run.
REQ-033 exchange_cmd SHALL be NOP in every state except PAIR_REQ, PAIR_WAIT and APPLY.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE; opt_run, pair_req, cmd_valid, busy and done = 0; pair_idx=0; exchange_cmd all NOP; round_cnt=0; parity=0; sweep counter=0.
REQ-035 Reset asserted mid-run SHALL abandon the run with no done pulse; after release, the block waits in IDLE for a new start.

Verification
REQ-036 Run with REPLICA_NUM=4, OPT_CYCLES=2, total_rounds=1, all accepts=1 -> exactly 2 opt_run pulses; pair_idx sequence 0,2; exchange_cmd={PREV,FOLW,PREV,FOLW} (entry3..entry0); round_cnt=1; one done pulse.
REQ-037 Run with REPLICA_NUM=4, total_rounds=2, accepts=0 in round 1 and 1 in round 2 -> round 1: all SELF; round 2 (parity 1): pair_idx=1 only, exchange_cmd={SELF,PREV,FOLW,SELF}.
REQ-038 Run with REPLICA_NUM=5, parity 0 -> pairs 0 and 2 only, entry4=SELF; parity 1 -> pairs 1 and 3, entry0=SELF.
REQ-039 total_rounds=0 -> busy high for 1 cycle, done pulse, no opt_run and no pair_req.
REQ-040 cmd_ready held low for 5 cycles in APPLY -> cmd_valid and exchange_cmd stable all 5 cycles; spurious opt_done/pair_ack/start during that time cause no effect.
REQ-041 rst_n pulsed low in PAIR_WAIT -> all outputs immediately return to reset values with no done pulse; a new start then runs normally from round_cnt=0.
